i2c_master_nbyte: RTL and testbench
===================================

// Module: i2c_master_nbyte
// PURPOSE
// - Parametrised I2C master; single-master bus, 7-bit addressing.
// - Runs one transfer per start: START, address+R/W, then 0..MAX_BYTES data bytes (write or read), then STOP.
// - Generates its own quarter-bit tick from clk.
// - Supports slave clock stretching and reads with master ACK/NACK.
// - Reports slave NACK; a NACK aborts the transfer.
// - Sits between a register/command front-end and the open-drain pads.
// PARAMETERS
// CLK_DIV    4  clk cycles per quarter SCL period; legal range >= 2
// MAX_BYTES  4  maximum data bytes per transfer; legal range >= 1
// LEN_W      $clog2(MAX_BYTES+1)  width of num_bytes (derived localparam)
// PORTS
// clk         in     1              system clock
// rst_n       in     1              asynchronous, active-low reset
// start       in     1              request pulse; accepted only in IDLE
// rw          in     1              0 = write, 1 = read
// slave_addr  in     7              target address, sent MSB first
// num_bytes   in     LEN_W          data byte count; values above MAX_BYTES are clamped to MAX_BYTES
// wdata       in     8*MAX_BYTES    byte k = wdata[8k+7:8k]; byte 0 sent first, MSB first
// rdata       out    8*MAX_BYTES    byte k = rdata[8k+7:8k], same ordering as wdata
// busy        out    1              high from the cycle after acceptance until done
// done        out    1              one-cycle pulse when STOP completes
// nack        out    1              slave NACKed; held until the next accepted start
// sda         inout  1              open drain: drives 0 or Z; input sampled
// scl         inout  1              open drain: drives 0 or Z; input sampled (for stretching)
// BEHAVIOUR
// - Reset: sda/scl released (Z), busy=0, done=0, nack=0, rdata=0, state IDLE, quarter=0, divider=0.
// - Acceptance: start in IDLE latches rw, addr, clamped count and wdata; clears nack.
//   - For a read, acceptance also clears rdata.
//   - busy rises the next cycle. A start while busy is ignored.
// - Tick: divider counts 0..CLK_DIV-1; tick fires when the count is CLK_DIV-1; divider held at 0 in IDLE.
// - Each bit has four quarters q0..q3, advanced by tick. State changes only at the end of q3.
//   - q0: SCL low; SDA driven with the new bit.
//   - q1: SCL released.
//   - q2: SCL high; SDA sampled on the final tick of q2.
//   - q3: SCL low.
// - Stretch: in q1, while the sampled scl is 0, the quarter does not advance (ticks ignored).
// - States (typedef i2c_nb_state_t):
//   - IDLE: bus released.
//   - START: (SDA,SCL) = q0 1/1, q1-q2 0/1, q3 0/0.
//   - ADDR: 8 bits (addr[6:0], then rw) -> ADDR_ACK.
//   - ADDR_ACK: SDA released.
//     - sampled 1 -> nack=1, then STOP.
//     - count 0 -> STOP.
//     - rw=0 -> WR_BYTE; rw=1 -> RD_BYTE.
//   - WR_BYTE: 8 bits -> WR_ACK.
//   - WR_ACK: sampled 1 -> nack=1, then STOP. Last byte -> STOP. Otherwise WR_BYTE with byte index +1.
//   - RD_BYTE: SDA released; 8 bits shifted into rdata byte k -> RD_ACK.
//   - RD_ACK: master drives 0 (ACK) if more bytes remain, 1 (NACK) on the last byte.
//     - Next: RD_BYTE or STOP.
//   - STOP: (SDA,SCL) = q0 0/0, q1 0/1, q2-q3 1/1.
//     - On the final q3 tick: done=1 for one cycle, busy=0, go to IDLE.
// - Duration (no stretch): 4*(11 + 9*N) quarters for N bytes fully ACKed.
//   - A NACK shortens the transfer: STOP follows the ACK bit directly.
// - rdata bytes at index >= N keep the cleared value. The write path never changes rdata.
// - Reset mid-transfer: bus released immediately (asynchronous). No done pulse.
// STRUCTURE
// - i2c_pkg: i2c_nb_state_t enum; constants Q0..Q3; I2C_ADDR_BITS = 7.
// - Sub-module i2c_quarter_tick: CLK_DIV divider with an enable input.
//   - Tick output is gated off while the stretch hold is active.
// - Top level: FSM plus bit/byte counters and shift registers.
// TESTING
// 1. Write N=2, addr 0x50, wdata[15:0] = 0x3CA5, slave ACKs.
//    -> SDA bytes 0xA0, 0xA5, 0x3C, each followed by ACK; nack=0; done after 116 quarters (CLK_DIV=4: 464 clk).
// 2. Read N=3, addr 0x48, slave returns 0x12, 0x34, 0x56.
//    -> rdata[23:0] = 0x563412; master ACKs bytes 0-1 and NACKs byte 2; done pulse.
// 3. Write N=2, addr 0x51, slave NACKs the address.
//    -> nack=1; STOP right after the ACK bit; no data bits on the bus; done after 44 quarters.
// 4. Slave holds SCL low for 10 clk during address bit 3.
//    -> q1 extended by 10 clk; all SDA bit values unchanged; total transfer time +10 clk.
// 5. Probe N=0, address ACKed -> START, address, ACK, STOP; nack=0; done.
//    Repeat with num_bytes = MAX_BYTES+3 -> exactly MAX_BYTES bytes transferred.
// 6. start pulsed while busy -> ignored; no second transaction.
//    rst_n asserted during WR_BYTE -> sda/scl Z and busy=0 within the same cycle; no done pulse.

Source files
------------

// File: rtl/i2c_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : i2c_pkg                                                          |
// | Shared state encoding and bit-quarter constants for the N-byte I2C master. |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
package i2c_pkg;

    localparam int I2C_ADDR_BITS = 7;

    // Quarter index within one SCL bit period
    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        START    = 4'd1,
        ADDR     = 4'd2,
        ADDR_ACK = 4'd3,
        WR_BYTE  = 4'd4,
        WR_ACK   = 4'd5,
        RD_BYTE  = 4'd6,
        RD_ACK   = 4'd7,
        STOP     = 4'd8
    } i2c_nb_state_t;

endpackage
`default_nettype wire

// File: rtl/i2c_quarter_tick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : i2c_quarter_tick                                                 |
// | Divides clk down to a quarter-bit tick; freezes while SCL is stretched.    |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module i2c_quarter_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic hold_i,
    output logic tick_o
);

    localparam int              CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    // Divider: parked at zero when disabled, frozen during a stretch hold so
    // the stretched quarter is lengthened by exactly the hold time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!en_i) begin
            cnt_q <= '0;
        end else if (!hold_i) begin
            cnt_q <= (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    assign tick_o = en_i && !hold_i && (cnt_q == CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/i2c_master_nbyte.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : i2c_master_nbyte                                                 |
// | Single-master 7-bit I2C master: START, addr+R/W, 0..MAX_BYTES data, STOP.  |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module i2c_master_nbyte
    import i2c_pkg::*;
#(
    parameter  int CLK_DIV   = 4,
    parameter  int MAX_BYTES = 4,
    localparam int LEN_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       rw,
    input  logic [I2C_ADDR_BITS-1:0]   slave_addr,
    input  logic [LEN_W-1:0]           num_bytes,
    input  logic [8*MAX_BYTES-1:0]     wdata,
    output logic [8*MAX_BYTES-1:0]     rdata,
    output logic                       busy,
    output logic                       done,
    output logic                       nack,
    inout  wire                        sda,
    inout  wire                        scl
);

    localparam int IDX_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

    i2c_nb_state_t            state_q, state_d;
    logic [1:0]               quarter_q, quarter_d;
    logic [2:0]               bit_q, bit_d;
    logic [IDX_W-1:0]         byte_q, byte_d;

    logic                     rw_q;
    logic [I2C_ADDR_BITS-1:0] addr_q;
    logic [LEN_W-1:0]         count_q;
    logic [8*MAX_BYTES-1:0]   wdata_q;
    logic [8*MAX_BYTES-1:0]   rdata_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     nack_q;
    logic                     ack_q;

    logic                     w_tick;
    logic                     w_hold;
    logic                     w_accept;
    logic                     w_last_byte;
    logic [LEN_W-1:0]         w_count;
    logic [2:0]               w_bit_sel;
    logic [7:0]               w_addr_byte;
    logic [8*MAX_BYTES-1:0]   w_wr_shift;
    logic [IDX_W+2:0]         w_rd_idx;
    logic                     w_sda_low;
    logic                     w_scl_low;

    assign w_accept    = (state_q == IDLE) && start;
    assign w_count     = (num_bytes > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : num_bytes;
    assign w_last_byte = ((LEN_W'(byte_q) + LEN_W'(1)) == count_q);
    assign w_bit_sel   = 3'd7 - bit_q;
    assign w_addr_byte = {addr_q, rw_q};
    assign w_wr_shift  = wdata_q >> {byte_q, 3'b000};
    assign w_rd_idx    = {byte_q, w_bit_sel};

    // A slave holding SCL low while we have released it freezes the quarter
    assign w_hold = (state_q != IDLE) && (quarter_q == Q1) && !scl;

    i2c_quarter_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (state_q != IDLE),
        .hold_i (w_hold),
        .tick_o (w_tick)
    );

    // State, quarter and bit/byte position registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            quarter_q <= Q0;
            bit_q     <= '0;
            byte_q    <= '0;
        end else begin
            state_q   <= state_d;
            quarter_q <= quarter_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
        end
    end

    // Next state: quarters advance on tick, states change only at the end of q3
    always_comb begin
        state_d   = state_q;
        quarter_d = quarter_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        if (state_q == IDLE) begin
            quarter_d = Q0;
            bit_d     = '0;
            byte_d    = '0;
            if (start) begin
                state_d = START;
            end
        end else if (w_tick) begin
            quarter_d = quarter_q + 2'd1;
            if (quarter_q == Q3) begin
                case (state_q)
                    START: begin
                        state_d = ADDR;
                        bit_d   = '0;
                    end
                    ADDR: begin
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = ADDR_ACK;
                    end
                    ADDR_ACK: begin
                        bit_d  = '0;
                        byte_d = '0;
                        if (ack_q || (count_q == '0)) state_d = STOP;
                        else if (rw_q)                state_d = RD_BYTE;
                        else                          state_d = WR_BYTE;
                    end
                    WR_BYTE: begin
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = WR_ACK;
                    end
                    WR_ACK: begin
                        bit_d = '0;
                        if (ack_q || w_last_byte) begin
                            state_d = STOP;
                        end else begin
                            state_d = WR_BYTE;
                            byte_d  = byte_q + IDX_W'(1);
                        end
                    end
                    RD_BYTE: begin
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = RD_ACK;
                    end
                    RD_ACK: begin
                        bit_d = '0;
                        if (w_last_byte) begin
                            state_d = STOP;
                        end else begin
                            state_d = RD_BYTE;
                            byte_d  = byte_q + IDX_W'(1);
                        end
                    end
                    STOP:    state_d = IDLE;
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // Transfer context latch, SDA sampling, read capture and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rw_q    <= 1'b0;
            addr_q  <= '0;
            count_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            nack_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (w_accept) begin
                rw_q    <= rw;
                addr_q  <= slave_addr;
                count_q <= w_count;
                wdata_q <= wdata;
                nack_q  <= 1'b0;
                busy_q  <= 1'b1;
                if (rw) rdata_q <= '0;
            end
            if (w_tick && (quarter_q == Q2)) begin
                ack_q <= sda;
                if (state_q == RD_BYTE) begin
                    rdata_q[w_rd_idx] <= sda;
                end
                if (((state_q == ADDR_ACK) || (state_q == WR_ACK)) && sda) begin
                    nack_q <= 1'b1;
                end
            end
            if (w_tick && (quarter_q == Q3) && (state_q == STOP)) begin
                done_q <= 1'b1;
                busy_q <= 1'b0;
            end
        end
    end

    // Open-drain pull-down requests derived from registered state only
    always_comb begin
        w_sda_low = 1'b0;
        w_scl_low = 1'b0;
        case (state_q)
            START: begin
                w_sda_low = (quarter_q != Q0);
                w_scl_low = (quarter_q == Q3);
            end
            STOP: begin
                w_sda_low = (quarter_q == Q0) || (quarter_q == Q1);
                w_scl_low = (quarter_q == Q0);
            end
            ADDR: begin
                w_sda_low = !w_addr_byte[w_bit_sel];
                w_scl_low = (quarter_q == Q0) || (quarter_q == Q3);
            end
            WR_BYTE: begin
                w_sda_low = !w_wr_shift[w_bit_sel];
                w_scl_low = (quarter_q == Q0) || (quarter_q == Q3);
            end
            RD_ACK: begin
                w_sda_low = !w_last_byte;
                w_scl_low = (quarter_q == Q0) || (quarter_q == Q3);
            end
            ADDR_ACK, WR_ACK, RD_BYTE: begin
                w_scl_low = (quarter_q == Q0) || (quarter_q == Q3);
            end
            default: begin
                w_sda_low = 1'b0;
                w_scl_low = 1'b0;
            end
        endcase
    end

    assign sda   = w_sda_low ? 1'b0 : 1'bz;
    assign scl   = w_scl_low ? 1'b0 : 1'bz;
    assign rdata = rdata_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign nack  = nack_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_nbyte.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_i2c_master_nbyte                                              |
// | Self-checking bench with a behavioural I2C slave and a frame scoreboard.   |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_i2c_master_nbyte;

    localparam int CLK_DIV   = 4;
    localparam int MAX_BYTES = 4;
    localparam int LEN_W     = $clog2(MAX_BYTES + 1);

    logic                   clk;
    logic                   rst_n;
    logic                   start;
    logic                   rw;
    logic [6:0]             slave_addr;
    logic [LEN_W-1:0]       num_bytes;
    logic [8*MAX_BYTES-1:0] wdata;
    logic [8*MAX_BYTES-1:0] rdata;
    logic                   busy;
    logic                   done;
    logic                   nack;
    wire                    sda_w;
    wire                    scl_w;

    pullup (sda_w);
    pullup (scl_w);

    logic slv_sda_low;
    logic slv_scl_low;
    assign sda_w = slv_sda_low ? 1'b0 : 1'bz;
    assign scl_w = slv_scl_low ? 1'b0 : 1'bz;

    i2c_master_nbyte #(
        .CLK_DIV   (CLK_DIV),
        .MAX_BYTES (MAX_BYTES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .rw         (rw),
        .slave_addr (slave_addr),
        .num_bytes  (num_bytes),
        .wdata      (wdata),
        .rdata      (rdata),
        .busy       (busy),
        .done       (done),
        .nack       (nack),
        .sda        (sda_w),
        .scl        (scl_w)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    // Scoreboard: each entry is {byte seen on the bus, ACK bit that followed}
    logic [8:0] exp_q [$];
    logic [8:0] obs_q [$];

    // Behavioural slave state
    bit         slv_ack_addr = 1'b1;
    logic [7:0] slv_rd [$];
    logic [7:0] sh;
    logic [7:0] cur_rd;
    int         bitn;
    int         frame;
    int         rd_idx;
    bit         got_pos;
    bit         smp;
    bit         is_read;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        if (done === 1'b1) done_cnt++;
    end

    // START: SDA falls while SCL is high
    initial forever begin
        @(negedge sda_w);
        if (scl_w === 1'b1) begin
            bitn = 0; frame = 0; rd_idx = 0;
            got_pos = 1'b0; is_read = 1'b0; slv_sda_low = 1'b0;
        end
    end

    initial forever begin
        @(posedge scl_w);
        smp     = (sda_w !== 1'b0);
        got_pos = 1'b1;
    end

    // Bit completed on SCL fall: shift, log frames, set up next SDA value
    initial forever begin
        @(negedge scl_w);
        if (got_pos) begin
            got_pos = 1'b0;
            if (bitn < 8) begin
                sh = {sh[6:0], smp};
                bitn++;
                if (frame > 0 && is_read) begin
                    if (bitn < 8) slv_sda_low = !cur_rd[7-bitn];
                    else          slv_sda_low = 1'b0;
                end
                if (bitn == 8) begin
                    if (frame == 0) begin
                        is_read     = sh[0];
                        slv_sda_low = slv_ack_addr;
                    end else if (!is_read) begin
                        slv_sda_low = 1'b1;
                    end
                end
            end else begin
                obs_q.push_back({sh, smp});
                bitn        = 0;
                frame++;
                slv_sda_low = 1'b0;
                if (is_read && !smp && rd_idx < slv_rd.size()) begin
                    cur_rd      = slv_rd[rd_idx];
                    rd_idx++;
                    slv_sda_low = !cur_rd[7];
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Issue one transfer; returns clk edges from acceptance to done (bounded)
    task automatic do_xfer(input bit r, input logic [6:0] a, input logic [LEN_W-1:0] n,
                           input logic [31:0] wd, output int cyc, output bit ok,
                           output logic busy_acc, output logic nack_acc);
        start = 1'b1; rw = r; slave_addr = a; num_bytes = n; wdata = wd;
        @(posedge clk);
        #1;
        start    = 1'b0;
        busy_acc = busy;
        nack_acc = nack;
        ok       = 1'b0;
        cyc      = 0;
        for (int i = 1; i <= 3000; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                cyc = i;
                ok  = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
        n_checks++; if (done !== 1'b0)  begin n_fail++; $display("FAIL reset_done: got %b, required 0", done); end
        n_checks++; if (nack !== 1'b0)  begin n_fail++; $display("FAIL reset_nack: got %b, required 0", nack); end
        n_checks++; if (rdata !== '0)   begin n_fail++; $display("FAIL reset_rdata: got %h, required 0", rdata); end
        n_checks++; if (sda_w !== 1'b1) begin n_fail++; $display("FAIL reset_sda: got %b, required 1", sda_w); end
        n_checks++; if (scl_w !== 1'b1) begin n_fail++; $display("FAIL reset_scl: got %b, required 1", scl_w); end
    endtask

    task automatic test_write();
        int cyc; bit ok; logic ba, na; logic [8:0] e, o;
        obs_q.delete(); slv_ack_addr = 1'b1;
        exp_q.push_back({8'hA0, 1'b0}); exp_q.push_back({8'hA5, 1'b0}); exp_q.push_back({8'h3C, 1'b0});
        do_xfer(1'b0, 7'h50, 3'd2, 32'h0000_3CA5, cyc, ok, ba, na);
        n_checks++; if (!ok)          begin n_fail++; $display("FAIL write_done: got timeout, required done"); end
        n_checks++; if (cyc != 464)   begin n_fail++; $display("FAIL write_cycles: got %0d, required 464", cyc); end
        n_checks++; if (ba !== 1'b1)  begin n_fail++; $display("FAIL write_busy_rise: got %b, required 1", ba); end
        n_checks++; if (nack !== 1'b0) begin n_fail++; $display("FAIL write_nack: got %b, required 0", nack); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL write_busy_end: got %b, required 0", busy); end
        n_checks++; if (rdata !== '0) begin n_fail++; $display("FAIL write_rdata: got %h, required 0", rdata); end
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL write_frames: got %0d, required %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL write_frame: got %h, required %h", o, e); end
        end
        exp_q.delete();
    endtask

    task automatic test_read();
        int cyc; bit ok; logic ba, na; logic [8:0] e, o;
        obs_q.delete(); slv_ack_addr = 1'b1;
        slv_rd = '{8'h12, 8'h34, 8'h56};
        exp_q.push_back({8'h91, 1'b0}); exp_q.push_back({8'h12, 1'b0});
        exp_q.push_back({8'h34, 1'b0}); exp_q.push_back({8'h56, 1'b1});
        do_xfer(1'b1, 7'h48, 3'd3, 32'hFFFF_FFFF, cyc, ok, ba, na);
        n_checks++; if (!ok)          begin n_fail++; $display("FAIL read_done: got timeout, required done"); end
        n_checks++; if (cyc != 608)   begin n_fail++; $display("FAIL read_cycles: got %0d, required 608", cyc); end
        n_checks++; if (rdata !== 32'h0056_3412) begin n_fail++; $display("FAIL read_rdata: got %h, required 00563412", rdata); end
        n_checks++; if (nack !== 1'b0) begin n_fail++; $display("FAIL read_nack: got %b, required 0", nack); end
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL read_frames: got %0d, required %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL read_frame: got %h, required %h", o, e); end
        end
        exp_q.delete();
        // A second, single-byte read must clear the bytes left from the first
        obs_q.delete();
        slv_rd = '{8'hEE};
        do_xfer(1'b1, 7'h48, 3'd1, 32'h0, cyc, ok, ba, na);
        n_checks++; if (rdata !== 32'h0000_00EE) begin n_fail++; $display("FAIL read_clear: got %h, required 000000ee", rdata); end
        obs_q.delete();
    endtask

    task automatic test_addr_nack();
        int cyc; bit ok; logic ba, na; logic [8:0] e, o;
        obs_q.delete(); slv_ack_addr = 1'b0;
        exp_q.push_back({8'hA2, 1'b1});
        do_xfer(1'b0, 7'h51, 3'd2, 32'h0000_BEEF, cyc, ok, ba, na);
        n_checks++; if (!ok)          begin n_fail++; $display("FAIL nack_done: got timeout, required done"); end
        n_checks++; if (cyc != 176)   begin n_fail++; $display("FAIL nack_cycles: got %0d, required 176", cyc); end
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if (nack !== 1'b1) begin n_fail++; $display("FAIL nack_flag: got %b, required 1", nack); end
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL nack_frames: got %0d, required %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL nack_frame: got %h, required %h", o, e); end
        end
        exp_q.delete();
        slv_ack_addr = 1'b1;
    endtask

    task automatic test_stretch();
        int cyc; bit ok; logic ba, na; logic [8:0] e, o;
        obs_q.delete();
        exp_q.push_back({8'hA0, 1'b0}); exp_q.push_back({8'hA5, 1'b0}); exp_q.push_back({8'h3C, 1'b0});
        fork
            do_xfer(1'b0, 7'h50, 3'd2, 32'h0000_3CA5, cyc, ok, ba, na);
            begin
                // Address bit 3 q1 begins 68 clk after acceptance; hold SCL 10 clk into it
                @(posedge busy);
                repeat (66) @(posedge clk);
                #1 slv_scl_low = 1'b1;
                repeat (12) @(posedge clk);
                #1 slv_scl_low = 1'b0;
            end
        join
        n_checks++; if (na !== 1'b0)  begin n_fail++; $display("FAIL stretch_nack_clear: got %b, required 0", na); end
        n_checks++; if (cyc != 474)   begin n_fail++; $display("FAIL stretch_cycles: got %0d, required 474", cyc); end
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL stretch_frames: got %0d, required %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL stretch_frame: got %h, required %h", o, e); end
        end
        exp_q.delete();
    endtask

    task automatic test_probe_and_clamp();
        int cyc; bit ok; logic ba, na; logic [8:0] e, o;
        obs_q.delete();
        exp_q.push_back({8'hA0, 1'b0});
        do_xfer(1'b0, 7'h50, 3'd0, 32'h0, cyc, ok, ba, na);
        n_checks++; if (cyc != 176)   begin n_fail++; $display("FAIL probe_cycles: got %0d, required 176", cyc); end
        n_checks++; if (nack !== 1'b0) begin n_fail++; $display("FAIL probe_nack: got %b, required 0", nack); end
        exp_q.push_back({8'hA0, 1'b0}); exp_q.push_back({8'h11, 1'b0}); exp_q.push_back({8'h22, 1'b0});
        exp_q.push_back({8'h33, 1'b0}); exp_q.push_back({8'h44, 1'b0});
        do_xfer(1'b0, 7'h50, 3'(MAX_BYTES + 3), 32'h4433_2211, cyc, ok, ba, na);
        n_checks++; if (cyc != 752)   begin n_fail++; $display("FAIL clamp_cycles: got %0d, required 752", cyc); end
        n_checks++; if (rdata !== 32'h0000_00EE) begin n_fail++; $display("FAIL clamp_rdata_kept: got %h, required 000000ee", rdata); end
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL probe_frames: got %0d, required %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL probe_frame: got %h, required %h", o, e); end
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        int cyc; bit ok; logic ba, na; int dc0; logic [8:0] e, o;
        obs_q.delete();
        dc0 = done_cnt;
        exp_q.push_back({8'hA0, 1'b0}); exp_q.push_back({8'h77, 1'b0});
        fork
            do_xfer(1'b0, 7'h50, 3'd1, 32'h0000_0077, cyc, ok, ba, na);
            begin
                @(posedge busy);
                repeat (20) @(posedge clk);
                #1 start = 1'b1; rw = 1'b1; slave_addr = 7'h10;
                @(posedge clk);
                #1 start = 1'b0;
            end
        join
        repeat (400) @(posedge clk);
        #1;
        n_checks++; if (cyc != 320)   begin n_fail++; $display("FAIL b2b_cycles: got %0d, required 320", cyc); end
        n_checks++; if (done_cnt - dc0 != 1) begin n_fail++; $display("FAIL b2b_done_count: got %0d, required 1", done_cnt - dc0); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy: got %b, required 0", busy); end
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_frames: got %0d, required %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL b2b_frame: got %h, required %h", o, e); end
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        int dc0;
        dc0 = done_cnt;
        start = 1'b1; rw = 1'b0; slave_addr = 7'h50; num_bytes = 3'd2; wdata = 32'h0000_00FF;
        @(posedge clk);
        #1 start = 1'b0;
        // 160 clk after acceptance: q0 of WR_BYTE bit 0, SCL driven low
        repeat (160) @(posedge clk);
        #1;
        n_checks++; if (scl_w !== 1'b0) begin n_fail++; $display("FAIL rstmid_scl_before: got %b, required 0", scl_w); end
        n_checks++; if (busy !== 1'b1)  begin n_fail++; $display("FAIL rstmid_busy_before: got %b, required 1", busy); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (sda_w !== 1'b1) begin n_fail++; $display("FAIL rstmid_sda: got %b, required 1", sda_w); end
        n_checks++; if (scl_w !== 1'b1) begin n_fail++; $display("FAIL rstmid_scl: got %b, required 1", scl_w); end
        n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL rstmid_busy: got %b, required 0", busy); end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (600) @(posedge clk);
        #1;
        n_checks++; if (done_cnt != dc0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d, required %0d", done_cnt, dc0); end
        n_checks++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL rstmid_busy_after: got %b, required 0", busy); end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; rw = 1'b0; slave_addr = '0; num_bytes = '0; wdata = '0;
        slv_sda_low = 1'b0; slv_scl_low = 1'b0;
        bitn = 0; frame = 0; rd_idx = 0; got_pos = 1'b0; is_read = 1'b0; sh = '0; cur_rd = '0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_write();
        test_read();
        test_addr_nack();
        test_stretch();
        test_probe_and_clamp();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
